// File: rtl/count_monitor_pkg.sv
// Shared FSM encoding and default sizing for the count monitor.
package count_monitor_pkg;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRACK     = 2'd1,
    SATURATED = 2'd2
  } state_e;
endpackage

// File: rtl/count_monitor_sat_counter.sv
// Event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) q_d = '0;
    else if (inc && (q_q != '1)) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/count_monitor.sv
// Watches a free-running counter: coverage of every value, max->0 wraps
// and steps that are neither a hold nor a +1.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_count,
  input  logic              clear,
  output logic              seen_all,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err,
  output logic              err_sticky,
  output logic              tracking
);
  localparam int NVAL = 1 << WIDTH;
  localparam logic [WIDTH-1:0] MAXV = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [NVAL-1:0]  seen_q, seen_d;
  logic             seen_all_q, seen_all_d;
  logic             step_err_q, step_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             tracking_q, tracking_d;

  logic             checking, legal, wrap_inc;
  logic [WIDTH-1:0] prev_inc;

  // The first sample after reset/clear has no predecessor, so it is never checked.
  assign checking = in_valid && !clear && (state_q != IDLE);
  assign prev_inc = prev_q + 1'b1;
  assign legal    = (in_count == prev_q) || (in_count == prev_inc);
  assign wrap_inc = checking && (prev_q == MAXV) && (in_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (in_valid) begin
      case (state_q)
        IDLE:      state_d = (&seen_d) ? SATURATED : TRACK;
        TRACK:     state_d = (&seen_d) ? SATURATED : TRACK;
        SATURATED: state_d = SATURATED;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    seen_d       = seen_q;
    prev_d       = prev_q;
    step_err_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    if (clear) begin
      seen_d       = '0;
      prev_d       = '0;
      err_sticky_d = 1'b0;
    end else if (in_valid) begin
      seen_d[in_count] = 1'b1;
      prev_d           = in_count;
      step_err_d       = checking && !legal;
      err_sticky_d     = err_sticky_q | step_err_d;
    end
    seen_all_d = &seen_d;
    tracking_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      seen_q       <= '0;
      seen_all_q   <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      tracking_q   <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      seen_q       <= seen_d;
      seen_all_q   <= seen_all_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
      tracking_q   <= tracking_d;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (wrap_inc),
    .q   (wrap_cnt)
  );

  assign seen_all   = seen_all_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign tracking   = tracking_q;
endmodule
